// File: rtl/uart_rx_pp_pkg.sv
// Shared types and defaults for the UART RX ping-pong bank controller.
package uart_rx_pp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PEND,
    SWAP
  } state_e;

  localparam logic [15:0] IDLE_TIMEOUT_DEF = 16'd868;
  localparam logic [9:0]  FRAME_MAX_DEF    = 10'd1023;

endpackage

// File: rtl/uart_rx_pingpong_ctrl_if.sv
// RX byte input, dual FIFO write/empty and frame hand-off bundle.
interface uart_rx_pingpong_ctrl_if;

  logic       rx_byte_valid;
  logic [7:0] rx_byte;
  logic       uart_rx_fifo_wren_1;
  logic       uart_rx_fifo_wren_2;
  logic [7:0] uart_rx_fifo_wdata;
  logic       uart_rx_fifo_empty_1;
  logic       uart_rx_fifo_empty_2;
  logic       frame_ping_pong_flag;
  logic       frame_ready;
  logic [9:0] frame_len;

  modport master (
    input  rx_byte_valid,
    input  rx_byte,
    input  uart_rx_fifo_empty_1,
    input  uart_rx_fifo_empty_2,
    output uart_rx_fifo_wren_1,
    output uart_rx_fifo_wren_2,
    output uart_rx_fifo_wdata,
    output frame_ping_pong_flag,
    output frame_ready,
    output frame_len
  );

  modport slave (
    output rx_byte_valid,
    output rx_byte,
    output uart_rx_fifo_empty_1,
    output uart_rx_fifo_empty_2,
    input  uart_rx_fifo_wren_1,
    input  uart_rx_fifo_wren_2,
    input  uart_rx_fifo_wdata,
    input  frame_ping_pong_flag,
    input  frame_ready,
    input  frame_len
  );

endinterface

// File: rtl/uart_rx_idle_timer.sv
// Line-idle counter: clears on activity, saturates at TIMEOUT.
module uart_rx_idle_timer
  import uart_rx_pp_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic timeout_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (cnt_q != TIMEOUT)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Strobe in the last idle cycle so the close lands on the TIMEOUT-th edge.
  assign timeout_o = !clr_i && (cnt_q == TIMEOUT - 16'd1);

endmodule

// File: rtl/uart_rx_pingpong_ctrl.sv
// Ping-pong bank controller for dual UART RX FIFOs.
// UART_RX_PP_STAT_EN adds drop_cnt_o / frame_cnt_o statistics.
module uart_rx_pingpong_ctrl
  import uart_rx_pp_pkg::*;
#(
  parameter logic [15:0] IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter logic [9:0]  FRAME_MAX    = FRAME_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef UART_RX_PP_STAT_EN
  output logic [15:0] drop_cnt_o,
  output logic [15:0] frame_cnt_o,
`endif
  uart_rx_pingpong_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       flag_q, flag_d;
  logic       wren1_q, wren1_d;
  logic       wren2_q, wren2_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ready_q, ready_d;
  logic [9:0] len_q, len_d;
  logic [9:0] cnt_q, cnt_d;
  logic       accept, swap, rd_empty, timeout;

  assign swap     = (state_q == SWAP);
  assign accept   = bus.rx_byte_valid && (state_q != PEND);
  assign rd_empty = flag_q ? bus.uart_rx_fifo_empty_1
                           : bus.uart_rx_fifo_empty_2;

  uart_rx_idle_timer #(
    .TIMEOUT (IDLE_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.rx_byte_valid || swap),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    if (swap) begin
      flag_d  = !flag_q;
      len_d   = cnt_q;
      ready_d = 1'b1;
      cnt_d   = '0;
    end
    // A byte in the swap cycle opens the next frame as its first byte.
    if (accept) begin
      cnt_d   = swap ? 10'd1 : cnt_q + 10'd1;
      wdata_d = bus.rx_byte;
    end
    wren1_d = accept && !flag_d;
    wren2_d = accept && flag_d;
    unique case (state_q)
      IDLE: if (accept) state_d = FILL;
      FILL: if (timeout || (accept && cnt_d == FRAME_MAX))
              state_d = PEND;
      PEND: if (rd_empty) state_d = SWAP;
      SWAP: state_d = accept ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flag_q  <= 1'b0;
      wren1_q <= 1'b0;
      wren2_q <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      wren1_q <= wren1_d;
      wren2_q <= wren2_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.uart_rx_fifo_wren_1  = wren1_q;
  assign bus.uart_rx_fifo_wren_2  = wren2_q;
  assign bus.uart_rx_fifo_wdata   = wdata_q;
  assign bus.frame_ping_pong_flag = flag_q;
  assign bus.frame_ready          = ready_q;
  assign bus.frame_len            = len_q;

`ifdef UART_RX_PP_STAT_EN
  logic [15:0] drop_q, fcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (state_q == PEND && bus.rx_byte_valid && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      if (swap)
        fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign drop_cnt_o  = drop_q;
  assign frame_cnt_o = fcnt_q;
`endif

endmodule
